// File: rtl/font_port_arbiter_if.sv
// Bus bundle between the console pipeline, the host port and the font RAM.
// The master modport is the arbiter's view and the slave modport is the environment's view.
interface font_port_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_BITS  = 4
);
    logic                            vid_req;
    logic [ADDR_WIDTH-LINE_BITS-1:0] vid_char;
    logic [LINE_BITS-1:0]            vid_line;
    logic                            vid_valid;
    logic [DATA_WIDTH-1:0]           vid_data;
    logic                            vid_drop;
    logic [7:0]                      drop_cnt;

    logic                            host_req;
    logic                            host_we;
    logic [ADDR_WIDTH-1:0]           host_addr;
    logic [DATA_WIDTH-1:0]           host_wdata;
    logic                            host_ack;
    logic [DATA_WIDTH-1:0]           host_rdata;

    logic [ADDR_WIDTH-1:0]           rom_addr;
    logic                            rom_we;
    logic [DATA_WIDTH-1:0]           rom_din;
    logic [DATA_WIDTH-1:0]           rom_dout;

    modport master (
        input  vid_req, vid_char, vid_line,
        output vid_valid, vid_data, vid_drop, drop_cnt,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output rom_addr, rom_we, rom_din,
        input  rom_dout
    );

    modport slave (
        output vid_req, vid_char, vid_line,
        input  vid_valid, vid_data, vid_drop, drop_cnt,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  rom_addr, rom_we, rom_din,
        output rom_dout
    );
endinterface

// File: rtl/font_port_arbiter.sv
// Shares the single font RAM port between the video line fetch and the host req/ack port.
// States: IDLE = no host op in flight | BUSY = host op issued, waiting for its ack.
module font_port_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 8,
    parameter int LINE_BITS    = 4,
    parameter int HOST_TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    font_port_arbiter_if.master    bus_if
);
    localparam int WAIT_W = $clog2(HOST_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_TIMEOUT);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;
    logic                    tag_vld_q, tag_host_q;
    logic                    vid_valid_q, host_ack_q, drop_q;

    logic                            host_issue, vid_issue;
    logic [ADDR_WIDTH-LINE_BITS-1:0] vid_char;
    logic [LINE_BITS-1:0]            vid_line;

    assign vid_char = bus_if.vid_char;
    assign vid_line = bus_if.vid_line;

    always_comb begin
        host_issue = (state_q == ST_IDLE) && bus_if.host_req &&
                     (!bus_if.vid_req || (wait_q >= WAIT_MAX));
        vid_issue  = bus_if.vid_req && !host_issue;

        state_d    = state_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        din_d      = din_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            ST_IDLE: if (host_issue) state_d = ST_BUSY;
            ST_BUSY: if (host_ack_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Waiting only accrues while the host could have been granted.
        if (host_issue || !bus_if.host_req) begin
            wait_d = '0;
        end else if (state_q == ST_IDLE && wait_q < WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end

        if (host_issue) begin
            addr_d = bus_if.host_addr;
            we_d   = bus_if.host_we;
            din_d  = bus_if.host_wdata;
        end else if (vid_issue) begin
            addr_d = {vid_char, vid_line};
        end

        if (host_issue && bus_if.vid_req && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            din_q       <= '0;
            drop_cnt_q  <= '0;
            tag_vld_q   <= 1'b0;
            tag_host_q  <= 1'b0;
            vid_valid_q <= 1'b0;
            host_ack_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            din_q       <= din_d;
            drop_cnt_q  <= drop_cnt_d;
            // Tag follows the access through the RAM's one-cycle read register.
            tag_vld_q   <= host_issue || vid_issue;
            tag_host_q  <= host_issue;
            vid_valid_q <= tag_vld_q && !tag_host_q;
            host_ack_q  <= tag_vld_q && tag_host_q;
            drop_q      <= host_issue && bus_if.vid_req;
        end
    end

    assign bus_if.rom_addr   = addr_q;
    assign bus_if.rom_we     = we_q;
    assign bus_if.rom_din    = din_q;
    assign bus_if.vid_valid  = vid_valid_q;
    assign bus_if.vid_data   = bus_if.rom_dout;
    assign bus_if.vid_drop   = drop_q;
    assign bus_if.drop_cnt   = drop_cnt_q;
    assign bus_if.host_ack   = host_ack_q;
    assign bus_if.host_rdata = bus_if.rom_dout;
endmodule

// File: tb/tb_font_port_arbiter.sv
// Bench for font_port_arbiter: RAM model, cycle-indexed expectation table and directed plus random steps.
module tb_font_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int LB = 4;
    localparam int CB = AW - LB;
    localparam int TO = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    font_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BITS(LB)) bus ();

    font_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BITS(LB), .HOST_TIMEOUT(TO)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus_if (bus)
    );

    function automatic logic [DW-1:0] init_f(input int a);
        return DW'((a * 37 + 5) ^ (a >> 3));
    endfunction

    // Font RAM: registered read, read-before-write, contents survive reset.
    bit            ram_wr [1<<AW];
    logic [DW-1:0] ram    [1<<AW];
    always @(posedge clk) begin
        if (bus.rom_we === 1'b1) begin
            ram[bus.rom_addr]    <= bus.rom_din;
            ram_wr[bus.rom_addr] <= 1'b1;
        end
        bus.rom_dout <= ram_wr[bus.rom_addr] ? ram[bus.rom_addr] : init_f(int'(bus.rom_addr));
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: grant rules evaluated per edge, results filed under the cycle they appear in.
    int            cyc = 0;
    int            busy_until, wait_m, dcnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    bit            pend;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    logic [DW-1:0] gold [1<<AW];

    bit            ex_vv [4], ex_ha [4], ex_hrd [4], ex_drop [4], ex_we [4];
    logic [DW-1:0] ex_vd [4], ex_hd [4], ex_din [4];
    logic [7:0]    ex_dc [4];
    logic [AW-1:0] ex_addr [4];

    bit            d_vreq, d_hreq, d_hwe;
    logic [CB-1:0] d_vchar;
    logic [LB-1:0] d_vline;
    logic [AW-1:0] d_haddr;
    logic [DW-1:0] d_hwd;
    int            vmode;

    bit            m_ack, dut_ack, dut_drop, dut_vv;
    logic [DW-1:0] dut_rdata;

    task automatic model_reset();
        busy_until = -1;
        wait_m = 0;
        dcnt   = 0;
        m_addr = '0;
        m_din  = '0;
        pend   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex_vv[i] = 0; ex_ha[i] = 0; ex_hrd[i] = 0; ex_drop[i] = 0; ex_we[i] = 0;
            ex_vd[i] = '0; ex_hd[i] = '0; ex_din[i] = '0; ex_dc[i] = '0; ex_addr[i] = '0;
        end
    endtask

    task automatic model_edge(input int n);
        bit            busy, hiss, viss;
        int            s0, s1;
        logic [AW-1:0] va;
        if (pend) begin
            gold[pend_a] = pend_d;
            pend = 1'b0;
        end
        busy = (n <= busy_until);
        hiss = !busy && d_hreq && (!d_vreq || wait_m >= TO);
        viss = d_vreq && !hiss;
        va   = {d_vchar, d_vline};
        s0   = n % 4;
        s1   = (n + 1) % 4;
        ex_drop[s0] = hiss && d_vreq;
        if (ex_drop[s0] && dcnt < 255) dcnt++;
        ex_dc[s0] = 8'(dcnt);
        if (hiss) begin
            m_addr     = d_haddr;
            m_din      = d_hwd;
            busy_until = n + 2;
            if (d_hwe) begin
                pend   = 1'b1;
                pend_a = d_haddr;
                pend_d = d_hwd;
            end
        end else if (viss) begin
            m_addr = va;
        end
        ex_we[s0]   = hiss && d_hwe;
        ex_addr[s0] = m_addr;
        ex_din[s0]  = m_din;
        ex_vv[s1]   = viss;
        ex_vd[s1]   = gold[va];
        ex_ha[s1]   = hiss;
        ex_hrd[s1]  = hiss && !d_hwe;
        ex_hd[s1]   = gold[d_haddr];
        if (hiss || !d_hreq) wait_m = 0;
        else if (!busy && wait_m < TO) wait_m++;
    endtask

    task automatic check_cycle(input int s);
        chk("vid_valid", 32'(bus.vid_valid), 32'(ex_vv[s]));
        if (ex_vv[s]) chk("vid_data", 32'(bus.vid_data), 32'(ex_vd[s]));
        chk("host_ack", 32'(bus.host_ack), 32'(ex_ha[s]));
        if (ex_ha[s] && ex_hrd[s]) chk("host_rdata", 32'(bus.host_rdata), 32'(ex_hd[s]));
        chk("vid_drop", 32'(bus.vid_drop), 32'(ex_drop[s]));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(ex_dc[s]));
        chk("rom_we", 32'(bus.rom_we), 32'(ex_we[s]));
        chk("rom_addr", 32'(bus.rom_addr), 32'(ex_addr[s]));
        chk("rom_din", 32'(bus.rom_din), 32'(ex_din[s]));
    endtask

    task automatic step();
        int s;
        bus.vid_req    = d_vreq;
        bus.vid_char   = d_vchar;
        bus.vid_line   = d_vline;
        bus.host_req   = d_hreq;
        bus.host_we    = d_hwe;
        bus.host_addr  = d_haddr;
        bus.host_wdata = d_hwd;
        model_edge(cyc);
        @(posedge clk);
        @(negedge clk);
        s = cyc % 4;
        check_cycle(s);
        m_ack     = ex_ha[s];
        dut_ack   = (bus.host_ack === 1'b1);
        dut_drop  = (bus.vid_drop === 1'b1);
        dut_vv    = (bus.vid_valid === 1'b1);
        dut_rdata = bus.host_rdata;
        cyc++;
        if (vmode == 1) d_vline = d_vline + 1'b1;
    endtask

    task automatic rst_checks(input string pfx);
        chk({pfx, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        chk({pfx, "_rom_we"}, 32'(bus.rom_we), 32'd0);
        chk({pfx, "_rom_din"}, 32'(bus.rom_din), 32'd0);
        chk({pfx, "_vid_valid"}, 32'(bus.vid_valid), 32'd0);
        chk({pfx, "_vid_drop"}, 32'(bus.vid_drop), 32'd0);
        chk({pfx, "_host_ack"}, 32'(bus.host_ack), 32'd0);
        chk({pfx, "_drop_cnt"}, 32'(bus.drop_cnt), 32'd0);
    endtask

    // Holds host_req with stable fields until the model says the ack cycle has been checked.
    task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int gap, output int lat, output int drops,
                           output logic [DW-1:0] rdata);
        bit got_m;
        d_hreq = 1'b1; d_hwe = we; d_haddr = a; d_hwd = d;
        lat = -1; drops = 0; got_m = 1'b0; rdata = '0;
        for (int k = 1; k <= 200 && !got_m; k++) begin
            if (vmode == 1) d_vreq = (k - 1 != gap);
            step();
            if (dut_drop) drops++;
            if (dut_ack && lat < 0) begin
                lat   = k;
                rdata = dut_rdata;
            end
            got_m = m_ack;
        end
        d_hreq = 1'b0;
        if (vmode == 1) d_vreq = 1'b1;
        chk("host_ack_seen", 32'(lat > 0), 32'd1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            lat, drops, cnt;
        logic [DW-1:0] rd, old;
        bit            h_act;

        for (int i = 0; i < (1 << AW); i++) gold[i] = init_f(i);
        model_reset();
        vmode = 0;
        d_vreq = 0; d_vchar = '0; d_vline = '0;
        d_hreq = 0; d_hwe = 0; d_haddr = '0; d_hwd = '0;
        bus.vid_req = 0; bus.vid_char = '0; bus.vid_line = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;

        #1 rstn = 1'b0;
        #1 rst_checks("rst0");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Continuous video stream over character 0x41.
        vmode = 1; d_vreq = 1; d_vchar = CB'(7'h41); d_vline = '0;
        cnt = 0;
        repeat (16) begin step(); if (dut_vv) cnt++; end
        vmode = 0; d_vreq = 0;
        repeat (3) begin step(); if (dut_vv) cnt++; end
        chk("stream_count", 32'(cnt), 32'd16);

        // Host write then read-back with video idle.
        host_op(1'b1, AW'(11'h123), 8'hA5, -1, lat, drops, rd);
        chk("wr_latency", 32'(lat), 32'd2);
        step();
        host_op(1'b0, AW'(11'h123), 8'h00, -1, lat, drops, rd);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_data_a5", 32'(rd), 32'hA5);
        step();

        // Host slips into a one-cycle video gap without a drop.
        vmode = 1; d_vreq = 1; d_vchar = CB'(7'h22);
        repeat (3) step();
        host_op(1'b0, AW'(11'h0A7), 8'h00, 5, lat, drops, rd);
        chk("gap_latency", 32'(lat), 32'd7);
        chk("gap_drops", 32'(drops), 32'd0);
        chk("gap_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        repeat (2) step();

        // Host forced in after the timeout against continuous video.
        host_op(1'b0, AW'(11'h123), 8'h00, -1, lat, drops, rd);
        chk("force_latency", 32'(lat), 32'd66);
        chk("force_drops", 32'(drops), 32'd1);
        chk("force_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        chk("force_rd_data", 32'(rd), 32'hA5);
        repeat (2) step();

        // 300 forced issues saturate the drop counter.
        for (int i = 0; i < 300; i++) begin
            host_op(1'b0, AW'($urandom_range(2047)), 8'h00, -1, lat, drops, rd);
        end
        repeat (2) step();
        chk("drop_cnt_sat", 32'(bus.drop_cnt), 32'd255);
        vmode = 0; d_vreq = 0;
        repeat (3) step();

        // Reset lands one cycle after a write is issued.
        old = gold[11'h0F0];
        d_hreq = 1; d_hwe = 1; d_haddr = AW'(11'h0F0); d_hwd = ~old;
        step();
        rstn = 1'b0;
        #1 rst_checks("rst_mid");
        model_reset();
        d_hreq = 0; d_hwe = 0;
        bus.host_req = 0; bus.host_we = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        repeat (4) begin step(); if (dut_ack) cnt++; end
        chk("no_ack_after_rst", 32'(cnt), 32'd0);
        host_op(1'b0, AW'(11'h0F0), 8'h00, -1, lat, drops, rd);
        chk("rst_old_data", 32'(rd), 32'(old));
        step();

        // Random traffic with a protocol-following host agent.
        vmode = 2; h_act = 0;
        for (int i = 0; i < 800; i++) begin
            d_vreq  = ($urandom_range(4) != 0);
            d_vchar = ($urandom_range(1) == 1) ? CB'(7'h10) : CB'($urandom);
            d_vline = LB'($urandom);
            if (!h_act && $urandom_range(5) == 0) begin
                h_act   = 1;
                d_hreq  = 1;
                d_hwe   = ($urandom_range(1) == 1);
                d_haddr = AW'(11'h100 + $urandom_range(15));
                d_hwd   = DW'($urandom);
            end
            step();
            if (h_act && m_ack) begin
                h_act  = 0;
                d_hreq = 0;
            end
        end
        d_vreq = 0; d_hreq = 0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
